// File: rtl/uart_tx_engine.sv
// UART transmit serializer: pulls bytes from the TX FIFO head and shifts out
// start, 5-8 data bits LSB first, optional parity and 1/1.5/2 stop bits.
module uart_tx_engine #(
  parameter int OS_RATE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       baud_pulse,
  input  logic [7:0] fifo_dout,
  input  logic       fifo_empty,
  output logic       fifo_pop,
  input  logic [1:0] wls,
  input  logic       stb,
  input  logic       pen,
  input  logic       eps,
  input  logic       sp,
  input  logic       bc,
  output logic       tx,
  output logic       tx_idle,
  output logic       sreg_empty
);

  localparam int TW = $clog2(2 * OS_RATE);
  localparam logic [TW-1:0] BitLast    = TW'(OS_RATE - 1);
  localparam logic [TW-1:0] Stop15Last = TW'(OS_RATE * 3 / 2 - 1);
  localparam logic [TW-1:0] Stop2Last  = TW'(2 * OS_RATE - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t        state_q;
  logic [TW-1:0] tickCnt_q;
  logic [2:0]    bitCnt_q;
  logic [7:0]    shiftReg_q;
  logic          parAcc_q;
  logic [1:0]    wls_q;
  logic          stb_q;
  logic          pen_q;
  logic          eps_q;
  logic          sp_q;
  logic          tx_q;
  logic          pop_q;

  logic [TW-1:0] segLast_d;
  logic          segDone;
  logic          lastData;
  logic          parityBit;
  logic          startFrame;
  logic          line_d;

  // Only the stop segment can be longer than one bit time.
  always_comb begin
    segLast_d = BitLast;
    if (state_q == STOP && stb_q) begin
      segLast_d = (wls_q == 2'b00) ? Stop15Last : Stop2Last;
    end
  end

  assign segDone    = (state_q != IDLE) && baud_pulse && (tickCnt_q == segLast_d);
  assign lastData   = (bitCnt_q == ({1'b0, wls_q} + 3'd4));
  assign parityBit  = sp_q ? ~eps_q : (eps_q ? parAcc_q : ~parAcc_q);
  assign startFrame = ((state_q == IDLE) || (state_q == STOP && segDone)) && !fifo_empty;

  always_comb begin
    line_d = 1'b1;
    case (state_q)
      START:   line_d = 1'b0;
      DATA:    line_d = shiftReg_q[0];
      PARITY:  line_d = parityBit;
      default: line_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      tickCnt_q  <= '0;
      bitCnt_q   <= '0;
      shiftReg_q <= '0;
      parAcc_q   <= 1'b0;
      wls_q      <= '0;
      stb_q      <= 1'b0;
      pen_q      <= 1'b0;
      eps_q      <= 1'b0;
      sp_q       <= 1'b0;
      tx_q       <= 1'b1;
      pop_q      <= 1'b0;
    end else begin
      pop_q <= 1'b0;
      tx_q  <= bc ? 1'b0 : line_d;
      if (state_q != IDLE && baud_pulse) begin
        tickCnt_q <= segDone ? '0 : tickCnt_q + TW'(1);
      end
      // A new byte may be taken from IDLE or straight out of the final stop tick.
      if (startFrame) begin
        state_q    <= START;
        shiftReg_q <= fifo_dout;
        wls_q      <= wls;
        stb_q      <= stb;
        pen_q      <= pen;
        eps_q      <= eps;
        sp_q       <= sp;
        tickCnt_q  <= '0;
        bitCnt_q   <= '0;
        parAcc_q   <= 1'b0;
        pop_q      <= 1'b1;
      end else if (segDone) begin
        case (state_q)
          START: begin
            state_q  <= DATA;
            bitCnt_q <= '0;
          end
          DATA: begin
            parAcc_q   <= parAcc_q ^ shiftReg_q[0];
            shiftReg_q <= shiftReg_q >> 1;
            if (lastData) begin
              state_q <= pen_q ? PARITY : STOP;
            end else begin
              bitCnt_q <= bitCnt_q + 3'd1;
            end
          end
          PARITY:  state_q <= STOP;
          STOP:    state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign tx         = tx_q;
  assign fifo_pop   = pop_q;
  assign tx_idle    = (state_q == IDLE);
  assign sreg_empty = (state_q == IDLE) && fifo_empty;

endmodule

// File: doc/uart_tx_engine.md
Name: uart_tx_engine

Overview:
- UART transmit serializer that sits directly downstream of the 16-entry TX FIFO.
- Consumes the FIFO's first-word-fall-through head byte and drives the serial line: start, 5–8 data bits LSB first, optional parity, 1/1.5/2 stop bits.
- Bit timing comes from an external oversampling baud pulse at 16 pulses per bit.
- Line-control fields match the 16550-style LCR used elsewhere in the UART.

Parameters:
- OS_RATE, 16, baud_pulse ticks per serial bit; must be even, ≥4; 1.5-stop length = OS_RATE*3/2.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- baud_pulse  input  1  one-clk-wide oversample tick
- fifo_dout  input  8  FIFO head byte (valid whenever fifo_empty=0)
- fifo_empty  input  1  FIFO empty flag
- fifo_pop  output  1  one-clk pop strobe to FIFO pop_in
- wls  input  2  word length: 00=5, 01=6, 10=7, 11=8 bits
- stb  input  1  0=1 stop bit; 1=2 stop bits (1.5 if wls=00)
- pen  input  1  parity enable
- eps  input  1  even parity select
- sp  input  1  stick parity
- bc  input  1  break control
- tx  output  1  serial line
- tx_idle  output  1  1 when state=IDLE
- sreg_empty  output  1  1 when state=IDLE and fifo_empty=1

Behaviour:
- One clock domain. Synchronous active-high reset. Reset values:
  - state=IDLE, tx=1, fifo_pop=0
  - tick counter=0, bit counter=0, shift reg=0
  - tx_idle=1, sreg_empty follows fifo_empty.
- Reset mid-frame aborts the frame immediately: tx=1 on the next edge. The byte is lost; it has already been popped.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE → START, on an edge with fifo_empty=0:
  - Latch fifo_dout into the shift reg.
  - Latch wls/stb/pen/eps/sp into frame config; config changes mid-frame are ignored.
  - Clear tick counter.
  - fifo_pop=1 for exactly the next cycle. A second pop per byte is forbidden.
- Tick counter increments only on baud_pulse. A bit ends on the OS_RATE-th pulse; the counter clears.
- START: tx=0 for one bit time → DATA.
- DATA:
  - tx=shreg[0]; shift right at end of each bit.
  - After N bits (N=5+wls) → PARITY if pen=1, else STOP.
  - Bits above N are never transmitted.
- PARITY bit, computed over the N data bits only:
  - sp=1: bit = ~eps (stick).
  - sp=0, eps=1: even parity, bit = XOR of data.
  - sp=0, eps=0: odd parity, bit = ~XOR.
- STOP: tx=1 for OS_RATE ticks (stb=0), OS_RATE*3/2 (stb=1, wls=00), or 2*OS_RATE (stb=1, otherwise).
- End of STOP:
  - fifo_empty=0: load next byte same edge, go directly to START (no idle gap), pop as above.
  - Otherwise → IDLE.
- tx is registered: first start-bit low appears 1 clk after the load edge.
- bc=1 forces tx=0 combinationally-registered (next edge) in all states. The FSM keeps running and FIFO draining continues.
- baud_pulse while IDLE is ignored.
- fifo_empty rising during a frame has no effect.
- No underrun is possible: the engine never pops when fifo_empty=1.

Test Plan:
- Reset, then FIFO holds 0xA5; wls=11, pen=0, stb=0:
  - fifo_pop high exactly 1 clk after load.
  - tx sequence 0,1,0,1,0,0,1,0,1,1, each 16 pulses.
  - Then tx_idle=1 and sreg_empty=1.
- 0x0F with wls=01, pen=1, eps=1, sp=0 → 6 data bits 1,1,1,1,0,0; parity=0; then stop. Repeat with eps=0 → parity=1.
- Stick parity sp=1, pen=1: eps=1 → parity bit 0; eps=0 → parity bit 1; for any data byte.
- Stop timing:
  - wls=00, stb=1 → stop lasts 24 pulses.
  - wls=11, stb=1 → 32 pulses.
  - Changing stb mid-frame does not alter the current frame.
- Three bytes 0x55, 0x00, 0xFF queued:
  - Back-to-back frames with no idle bit between them.
  - Exactly 3 single-cycle pops.
  - sreg_empty=1 only after the final stop.
- Break and reset:
  - bc=1 mid-DATA → tx=0 from next edge; frame timing continues.
  - rst asserted mid-frame → tx=1, state IDLE, fifo_pop=0 next edge, no extra pop.
